adder_share_arbiter: RTL and testbench

//  - Shares one DATA_W-bit ripple adder (a + b + cin) among NREQ requesters.
//  - Round-robin arbiter grants one request per accept cycle and drives the shared adder.
//  - The sum is registered into a one-deep result buffer with a valid/ready handshake and

---
 rtl/adder_share_arbiter_if.sv | 40 ++++
 rtl/adder_share_arbiter.sv | 88 ++++++++
 tb/tb_adder_share_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - request/result bundle for the shared adder arbiter
// Optional req_sub lane is present only when ADDER_ARB_SUB_EN is defined.
interface adder_share_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic [NREQ-1:0]        req_cin;
  logic                   res_valid;
  logic                   res_ready;
  logic [DATA_W-1:0]      res_sum;
  logic                   res_cout;
  logic [ID_W-1:0]        res_id;
`ifdef ADDER_ARB_SUB_EN
  logic [NREQ-1:0]        req_sub;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id
  );
  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_sum, res_cout, res_id
  );
  modport slave (
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_sum, res_cout, res_id
  );
`endif
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one adder, one-deep result buffer
// Define ADDER_ARB_SUB_EN to add per-requester subtract (req_sub).
module adder_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [NREQ-1:0]   grant_oh;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_eff;
  logic              cin_eff;
  logic [DATA_W:0]   sum_full;
  logic [DATA_W-1:0] sum_q;
  logic              cout_q;
  logic [ID_W-1:0]   id_q;

  assign can_accept = (state == ST_EMPTY) || bus.res_ready;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant_oh      = NREQ'(1) << gnt_idx;
  assign bus.req_ready = (rst_n && found && can_accept) ? grant_oh : '0;
  assign accept        = |bus.req_ready;

  // Operand mux depends only on the grant, so ready never looks at operand data.
  always_comb begin
    a_sel   = bus.req_a[int'(gnt_idx)*DATA_W +: DATA_W];
    b_eff   = bus.req_b[int'(gnt_idx)*DATA_W +: DATA_W];
    cin_eff = bus.req_cin[gnt_idx];
`ifdef ADDER_ARB_SUB_EN
    if (bus.req_sub[gnt_idx]) begin
      b_eff   = ~b_eff;
      cin_eff = 1'b1;
    end
`endif
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_eff};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      sum_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      state  <= ST_FULL;
      sum_q  <= sum_full[DATA_W-1:0];
      cout_q <= sum_full[DATA_W];
      id_q   <= gnt_idx;
      rr_ptr <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if ((state == ST_FULL) && bus.res_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign bus.res_valid = (state == ST_FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
// Subtract vectors run only when ADDER_ARB_SUB_EN is defined.
module tb_adder_share_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 16;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_cmp;
  int   n_fail;

  adder_share_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  adder_share_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit        m_valid;
  int        m_sum;
  int        m_cout;
  int        m_id;
  int        m_ptr;

  function automatic int model_grant();
    if (!rst_n || (m_valid && !bus.res_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    g = model_grant();
    return (g < 0) ? '0 : NREQ'(1) << g;
  endfunction

  always @(posedge clk) begin
    int g;
    int a;
    int b;
    int c;
    int full;
    if (!rst_n) begin
      m_valid = 0; m_sum = 0; m_cout = 0; m_id = 0; m_ptr = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        a = int'(bus.req_a[g*DATA_W +: DATA_W]);
        b = int'(bus.req_b[g*DATA_W +: DATA_W]);
        c = int'(bus.req_cin[g]);
`ifdef ADDER_ARB_SUB_EN
        if (bus.req_sub[g]) begin
          b = 65535 - b;
          c = 1;
        end
`endif
        full    = a + b + c;
        m_sum   = full % 65536;
        m_cout  = full / 65536;
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % NREQ;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_req_ready", 64'(bus.req_ready), 64'(model_ready()));
      chk("model_res_valid", 64'(bus.res_valid), 64'(m_valid));
      chk("model_res_sum",   64'(bus.res_sum),   64'(m_sum));
      chk("model_res_cout",  64'(bus.res_cout),  64'(m_cout));
      chk("model_res_id",    64'(bus.res_id),    64'(m_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_cin[i] = cin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.res_ready = 1'b0;
`ifdef ADDER_ARB_SUB_EN
    bus.req_sub = '0;
`endif
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;

    // Single add on requester 1
    set_req(1, 16'h1234, 16'h0FF0, 1'b1);
    bus.req_valid = 4'b0010;
    #1 chk("single_ready", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    #1;
    chk("single_valid", 64'(bus.res_valid), 64'h1);
    chk("single_sum",   64'(bus.res_sum),   64'h2225);
    chk("single_cout",  64'(bus.res_cout),  64'h0);
    chk("single_id",    64'(bus.res_id),    64'h1);

    // Reset over a held result, all requesters valid
    for (int i = 0; i < NREQ; i++) set_req(i, 16'h1000 * (i + 1), 16'(i), 1'b0);
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    #1 chk("rst_ready_low", 64'(bus.req_ready), 64'h0);
    step();
    step();
    chk("rst_valid", 64'(bus.res_valid), 64'h0);
    chk("rst_sum",   64'(bus.res_sum),   64'h0);
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    #1 chk("post_rst_grant0", 64'(bus.req_ready), 64'h1);

    // Round robin: ids 0,1,2,3,0 one per cycle
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_valid", 64'(bus.res_valid), 64'h1);
      chk("rr_id",    64'(bus.res_id),    64'(n % NREQ));
      chk("rr_sum",   64'(bus.res_sum),   64'(16'h1000 * ((n % NREQ) + 1) + (n % NREQ)));
    end
    bus.req_valid = '0;
    step();

    // Backpressure: hold a result from req0 while req2 waits
    set_req(0, 16'h0100, 16'h0023, 1'b1);
    set_req(2, 16'h4000, 16'h0abc, 1'b0);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 chk("bp_ready", 64'(bus.req_ready), 64'h0);
      step();
      chk("bp_valid", 64'(bus.res_valid), 64'h1);
      chk("bp_sum",   64'(bus.res_sum),   64'h0124);
      chk("bp_id",    64'(bus.res_id),    64'h0);
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_drain_ready", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid = '0;
    chk("bp_refill_valid", 64'(bus.res_valid), 64'h1);
    chk("bp_refill_id",    64'(bus.res_id),    64'h2);
    chk("bp_refill_sum",   64'(bus.res_sum),   64'h4abc);

    // Carry boundaries
    set_req(3, 16'hFFFF, 16'h0001, 1'b0);
    bus.req_valid = 4'b1000;
    step();
    chk("carry_sum",  64'(bus.res_sum),  64'h0);
    chk("carry_cout", 64'(bus.res_cout), 64'h1);
    chk("carry_id",   64'(bus.res_id),   64'h3);
    set_req(1, 16'hFFFF, 16'hFFFF, 1'b1);
    bus.req_valid = 4'b0010;
    step();
    chk("max_sum",  64'(bus.res_sum),  64'hFFFF);
    chk("max_cout", 64'(bus.res_cout), 64'h1);
    bus.req_valid = '0;

`ifdef ADDER_ARB_SUB_EN
    set_req(0, 16'h0005, 16'h0007, 1'b0);
    bus.req_sub = 4'b0001;
    bus.req_valid = 4'b0001;
    step();
    chk("sub_borrow_sum",  64'(bus.res_sum),  64'hFFFE);
    chk("sub_borrow_cout", 64'(bus.res_cout), 64'h0);
    set_req(2, 16'h0007, 16'h0005, 1'b0);
    bus.req_sub = 4'b0100;
    bus.req_valid = 4'b0100;
    step();
    chk("sub_sum",  64'(bus.res_sum),  64'h0002);
    chk("sub_cout", 64'(bus.res_cout), 64'h1);
    bus.req_valid = '0;
    bus.req_sub = '0;
`endif

    // Mixed traffic soak checked by the model only
    for (int n = 0; n < 60; n++) begin
      bus.req_valid = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        set_req(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
`ifdef ADDER_ARB_SUB_EN
      bus.req_sub = NREQ'($urandom_range(0, 15));
`endif
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    bus.req_valid = '0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
